// File: rtl/inst_fetch_if.sv
// Instruction-memory request/response bus between the IF stage and instruction memory.
interface inst_fetch_if;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;

    modport master (output inst_req, inst_addr, input inst_addr_ok, inst_data_ok, inst_rdata);
    modport slave  (input inst_req, inst_addr, output inst_addr_ok, inst_data_ok, inst_rdata);
endinterface

// File: rtl/inst_fetch.sv
// IF-stage fetch unit: owns the PC, keeps one memory request in flight, honours the
// branch delay slot and exception redirects, and feeds ID through a stall-able register.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
    parameter bit          EXC_DROP = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    input  logic               id_valid,
    input  logic               branch_taken,
    input  logic [31:0]        branch_address,
    input  logic               exception_valid,
    input  logic [31:0]        exception_address,
    inst_fetch_if.master       mem,
    output logic               if_valid,
    output logic [31:0]        if_instruction,
    output logic [31:0]        if_pc,
    output logic               if_addr_err
);
    typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, ERR} state_t;

    state_t      state, state_n;
    logic [31:0] pc, pc_n;
    logic        redir_pending, rp_n;
    logic [31:0] redir_target, rt_n;
    logic        drop, drop_n;
    logic        req_sent, req_sent_n;
    logic [31:0] buf_data, buf_n;
    logic        load, ld_err;
    logic [31:0] ld_instr, seq_pc;
    logic        aligned, branch_acc;

    assign aligned    = (pc[1:0] == 2'b00);
    // Branches seen while a dropped response is outstanding belong to the flushed stream.
    assign branch_acc = id_valid & branch_taken & ~stall & ~exception_valid & ~drop;
    assign seq_pc     = branch_acc    ? branch_address :
                        redir_pending ? redir_target   : pc + 32'd4;

    always_comb begin
        mem.inst_req  = (state == REQ) && aligned && (!stall || req_sent);
        mem.inst_addr = (state == REQ && aligned) ? pc : '0;
    end

    always_comb begin
        state_n    = state;
        pc_n       = pc;
        rp_n       = redir_pending;
        rt_n       = redir_target;
        drop_n     = drop;
        req_sent_n = req_sent;
        buf_n      = buf_data;
        load       = 1'b0;
        ld_instr   = mem.inst_rdata;
        ld_err     = 1'b0;
        if (branch_acc) begin
            rp_n = 1'b1;
            rt_n = branch_address;
        end
        unique case (state)
            IDLE: begin
                state_n = REQ;
                if (exception_valid) begin
                    pc_n = exception_address;
                    rp_n = 1'b0;
                end
            end
            REQ: begin
                // An issued request must complete; the exception vector waits in redir_target.
                if (mem.inst_req) begin
                    req_sent_n = !mem.inst_addr_ok;
                    if (mem.inst_addr_ok) state_n = WAIT;
                    if (exception_valid) begin
                        drop_n = EXC_DROP;
                        rp_n   = 1'b1;
                        rt_n   = exception_address;
                    end
                end else if (exception_valid) begin
                    pc_n = exception_address;
                    rp_n = 1'b0;
                end else if (!aligned && !stall) begin
                    load     = 1'b1;
                    ld_instr = '0;
                    ld_err   = 1'b1;
                    state_n  = ERR;
                end
            end
            WAIT: begin
                if (mem.inst_data_ok) begin
                    if (exception_valid) begin
                        pc_n = exception_address;
                        rp_n = 1'b0;
                        drop_n = 1'b0;
                        state_n = REQ;
                    end else if (drop) begin
                        pc_n = seq_pc;
                        rp_n = 1'b0;
                        drop_n = 1'b0;
                        state_n = REQ;
                    end else if (!stall) begin
                        load = 1'b1;
                        pc_n = seq_pc;
                        rp_n = 1'b0;
                        state_n = REQ;
                    end else begin
                        buf_n   = mem.inst_rdata;
                        state_n = HOLD;
                    end
                end else if (exception_valid) begin
                    drop_n = EXC_DROP;
                    rp_n   = 1'b1;
                    rt_n   = exception_address;
                end
            end
            HOLD: begin
                if (exception_valid) begin
                    pc_n = exception_address;
                    rp_n = 1'b0;
                    state_n = REQ;
                end else if (!stall) begin
                    load     = 1'b1;
                    ld_instr = buf_data;
                    pc_n     = seq_pc;
                    rp_n     = 1'b0;
                    state_n  = REQ;
                end
            end
            ERR: begin
                if (exception_valid) begin
                    pc_n = exception_address;
                    rp_n = 1'b0;
                    state_n = REQ;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            pc            <= RESET_PC;
            redir_pending <= 1'b0;
            redir_target  <= '0;
            drop          <= 1'b0;
            req_sent      <= 1'b0;
            buf_data      <= '0;
        end else begin
            state         <= state_n;
            pc            <= pc_n;
            redir_pending <= rp_n;
            redir_target  <= rt_n;
            drop          <= drop_n;
            req_sent      <= req_sent_n;
            buf_data      <= buf_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_valid       <= 1'b0;
            if_instruction <= '0;
            if_pc          <= '0;
            if_addr_err    <= 1'b0;
        end else if (exception_valid) begin
            if_valid    <= 1'b0;
            if_addr_err <= 1'b0;
        end else if (load) begin
            if_valid       <= 1'b1;
            if_instruction <= ld_instr;
            if_pc          <= pc;
            if_addr_err    <= ld_err;
        end else if (!stall) begin
            if_valid    <= 1'b0;
            if_addr_err <= 1'b0;
        end
    end
endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: cycle table, directed branch/exception/misalignment sequences,
// and a randomized run scored against an instruction-stream reference model.
module tb_inst_fetch;
    localparam logic [31:0] A = 32'hBFC0_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, id_valid, branch_taken, exception_valid;
    logic [31:0] branch_address, exception_address;
    logic        if_valid, if_addr_err;
    logic [31:0] if_instruction, if_pc;

    inst_fetch_if bus();

    inst_fetch #(.RESET_PC(A), .EXC_DROP(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .id_valid(id_valid),
        .branch_taken(branch_taken), .branch_address(branch_address),
        .exception_valid(exception_valid), .exception_address(exception_address),
        .mem(bus), .if_valid(if_valid), .if_instruction(if_instruction),
        .if_pc(if_pc), .if_addr_err(if_addr_err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int failed = 0;

    typedef struct {
        logic        stall, aok, dok;
        logic [31:0] rd_addr;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
    } vec_t;
    vec_t vec[14];

    // stimulus/model state
    logic        rand_mode = 1'b0, hand_mode = 1'b0, exc_now = 1'b0;
    logic [31:0] exc_addr_v = '0, br_pc = '0, br_tgt = '0;
    logic        outst, hold_req;
    int unsigned lat;
    logic [31:0] pend_addr, hold_addr;
    logic [31:0] req_log[$];
    logic [31:0] exp_pc, m_tgt;
    logic        m_pend, m_dead;
    int          n_deliv = 0, n_err = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ {a[15:0], a[31:16]} ^ 32'h3C1D_5A00;
    endfunction

    function automatic logic is_br(input logic [31:0] a);
        if (hand_mode) return a == br_pc;
        return (a[6:2] == 5'd7) && (a[1:0] == 2'b00);
    endfunction

    function automatic logic [31:0] br_target(input logic [31:0] a);
        if (hand_mode) return br_tgt;
        return A | ((a * 32'd13) & 32'h0000_0FFC);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset(input logic [31:0] start);
        exp_pc = start;
        m_pend = 1'b0;
        m_tgt  = '0;
        m_dead = 1'b0;
    endtask

    // One instruction accepted by ID: compare against the architectural fetch order.
    task automatic consume();
        logic        e_err;
        logic [31:0] e_ins, nxt;
        if (m_dead) begin
            chk("deliver_after_err", {31'b0, if_valid}, 32'd0);
        end else begin
            e_err = (exp_pc[1:0] != 2'b00);
            e_ins = e_err ? 32'h0 : mem_word(exp_pc);
            chk("deliver_pc", if_pc, exp_pc);
            chk("deliver_instr", if_instruction, e_ins);
            chk("deliver_err", {31'b0, if_addr_err}, {31'b0, e_err});
            n_deliv++;
            if (e_err) begin
                n_err++;
                m_dead = 1'b1;
            end else begin
                nxt    = m_pend ? m_tgt : exp_pc + 32'd4;
                m_pend = is_br(exp_pc);
                m_tgt  = br_target(exp_pc);
                exp_pc = nxt;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        stall = 1'b0; id_valid = 1'b0; branch_taken = 1'b0; branch_address = '0;
        exception_valid = 1'b0; exception_address = '0;
        bus.inst_addr_ok = 1'b0; bus.inst_data_ok = 1'b0; bus.inst_rdata = '0;
        outst = 1'b0; lat = 0; pend_addr = '0; hold_req = 1'b0; hold_addr = '0;
        exc_now = 1'b0;
        model_reset(A);
        #1;
        chk("rst_req", {31'b0, bus.inst_req}, 32'd0);
        chk("rst_addr", bus.inst_addr, 32'd0);
        chk("rst_valid", {31'b0, if_valid}, 32'd0);
        chk("rst_pc", if_pc, 32'd0);
        chk("rst_instr", if_instruction, 32'd0);
        chk("rst_err", {31'b0, if_addr_err}, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
    endtask

    // One clock of environment: ID follows the output register, memory answers the bus.
    task automatic step();
        @(negedge clk);
        stall             = rand_mode ? ($urandom_range(0, 3) == 0) : 1'b0;
        exception_valid   = exc_now;
        exception_address = exc_addr_v;
        id_valid          = if_valid;
        branch_taken      = if_valid && is_br(if_pc);
        branch_address    = br_target(if_pc);
        bus.inst_data_ok  = outst && (lat == 0);
        bus.inst_rdata    = bus.inst_data_ok ? mem_word(pend_addr) : $urandom();
        #1;
        if (hold_req) begin
            chk("req_held", {31'b0, bus.inst_req}, 32'd1);
            chk("addr_held", bus.inst_addr, hold_addr);
        end
        if (outst) chk("one_outstanding", {31'b0, bus.inst_req}, 32'd0);
        bus.inst_addr_ok = bus.inst_req && (rand_mode ? ($urandom_range(0, 1) == 1) : 1'b1);
        if (if_valid && !stall && !exc_now) consume();
        if (exc_now) model_reset(exc_addr_v);
        if (bus.inst_data_ok) outst = 1'b0;
        else if (outst && lat > 0) lat--;
        if (bus.inst_req && bus.inst_addr_ok) begin
            outst     = 1'b1;
            pend_addr = bus.inst_addr;
            lat       = rand_mode ? $urandom_range(0, 2) : 0;
            req_log.push_back(bus.inst_addr);
        end
        hold_req  = bus.inst_req && !bus.inst_addr_ok;
        hold_addr = bus.inst_addr;
        exc_now   = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int base, found;
        //           stall aok dok rd_addr  req addr    valid pc
        vec[0]  = '{1'b0, 1'b1, 1'b0, 32'h0,    1'b1, A,        1'b0, 32'h0};
        vec[1]  = '{1'b0, 1'b0, 1'b1, A,        1'b0, 32'h0,    1'b0, 32'h0};
        vec[2]  = '{1'b0, 1'b1, 1'b0, 32'h0,    1'b1, A + 4,    1'b1, A};
        vec[3]  = '{1'b0, 1'b0, 1'b1, A + 4,    1'b0, 32'h0,    1'b0, 32'h0};
        vec[4]  = '{1'b0, 1'b1, 1'b0, 32'h0,    1'b1, A + 8,    1'b1, A + 4};
        vec[5]  = '{1'b1, 1'b0, 1'b1, A + 8,    1'b0, 32'h0,    1'b0, 32'h0};
        vec[6]  = '{1'b1, 1'b0, 1'b0, 32'h0,    1'b0, 32'h0,    1'b0, 32'h0};
        vec[7]  = '{1'b1, 1'b0, 1'b0, 32'h0,    1'b0, 32'h0,    1'b0, 32'h0};
        vec[8]  = '{1'b0, 1'b0, 1'b0, 32'h0,    1'b0, 32'h0,    1'b0, 32'h0};
        vec[9]  = '{1'b1, 1'b0, 1'b0, 32'h0,    1'b0, 32'h0,    1'b1, A + 8};
        vec[10] = '{1'b1, 1'b0, 1'b0, 32'h0,    1'b0, 32'h0,    1'b1, A + 8};
        vec[11] = '{1'b0, 1'b1, 1'b0, 32'h0,    1'b1, A + 12,   1'b1, A + 8};
        vec[12] = '{1'b0, 1'b0, 1'b1, A + 12,   1'b0, 32'h0,    1'b0, 32'h0};
        vec[13] = '{1'b0, 1'b1, 1'b0, 32'h0,    1'b1, A + 16,   1'b1, A + 12};

        rst_n = 1'b0;
        do_reset();
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            stall            = vec[i].stall;
            bus.inst_addr_ok = vec[i].aok;
            bus.inst_data_ok = vec[i].dok;
            bus.inst_rdata   = mem_word(vec[i].rd_addr);
            #1;
            chk($sformatf("vec%0d_req", i), {31'b0, bus.inst_req}, {31'b0, vec[i].exp_req});
            if (vec[i].exp_req) chk($sformatf("vec%0d_addr", i), bus.inst_addr, vec[i].exp_addr);
            chk($sformatf("vec%0d_valid", i), {31'b0, if_valid}, {31'b0, vec[i].exp_valid});
            if (vec[i].exp_valid) begin
                chk($sformatf("vec%0d_pc", i), if_pc, vec[i].exp_pc);
                chk($sformatf("vec%0d_instr", i), if_instruction, mem_word(vec[i].exp_pc));
            end
        end

        // taken branch at A+10: delay slot A+14 still fetched, then the target
        do_reset();
        hand_mode = 1'b1; rand_mode = 1'b0;
        br_pc = A + 32'h10; br_tgt = A + 32'h100;
        req_log.delete();
        base = n_deliv;
        repeat (24) step();
        begin
            logic [31:0] exp_reqs [8];
            exp_reqs = '{A, A + 4, A + 8, A + 12, A + 16, A + 20, A + 32'h100, A + 32'h104};
            chk("branch_req_count", {31'b0, req_log.size() >= 8}, 32'd1);
            for (int i = 0; i < 8; i++)
                if (i < req_log.size()) chk($sformatf("branch_req%0d", i), req_log[i], exp_reqs[i]);
        end
        chk("branch_delivered", {31'b0, (n_deliv - base) >= 8}, 32'd1);

        // exception in WAIT together with a taken branch: response dropped, vector fetched
        do_reset();
        @(negedge clk);
        bus.inst_addr_ok = 1'b1;
        #1;
        chk("exc_first_req", {31'b0, bus.inst_req}, 32'd1);
        chk("exc_first_addr", bus.inst_addr, A);
        @(negedge clk);
        bus.inst_addr_ok = 1'b0;
        exception_valid = 1'b1; exception_address = A + 32'h380;
        id_valid = 1'b1; branch_taken = 1'b1; branch_address = A + 32'h200;
        #1;
        chk("exc_wait_noreq", {31'b0, bus.inst_req}, 32'd0);
        @(negedge clk);
        exception_valid = 1'b0; id_valid = 1'b0; branch_taken = 1'b0;
        bus.inst_data_ok = 1'b1; bus.inst_rdata = mem_word(A);
        #1;
        chk("exc_flush_valid", {31'b0, if_valid}, 32'd0);
        @(negedge clk);
        bus.inst_data_ok = 1'b0;
        #1;
        chk("exc_drop_valid", {31'b0, if_valid}, 32'd0);
        chk("exc_redirect_req", {31'b0, bus.inst_req}, 32'd1);
        chk("exc_redirect_addr", bus.inst_addr, A + 32'h380);
        bus.inst_addr_ok = 1'b1;
        @(negedge clk);
        bus.inst_addr_ok = 1'b0;
        bus.inst_data_ok = 1'b1; bus.inst_rdata = mem_word(A + 32'h380);
        #1;
        chk("exc_vec_wait_valid", {31'b0, if_valid}, 32'd0);
        @(negedge clk);
        bus.inst_data_ok = 1'b0;
        #1;
        chk("exc_vec_valid", {31'b0, if_valid}, 32'd1);
        chk("exc_vec_pc", if_pc, A + 32'h380);
        chk("exc_vec_instr", if_instruction, mem_word(A + 32'h380));

        // jump to a misaligned target, then recover via exception near the top of memory
        do_reset();
        hand_mode = 1'b1; rand_mode = 1'b0;
        br_pc = A + 8; br_tgt = 32'h0040_0002;
        req_log.delete();
        n_err = 0;
        repeat (20) step();
        found = 0;
        foreach (req_log[i]) if (req_log[i] == 32'h0040_0002) found++;
        chk("misaligned_no_req", found, 0);
        chk("misaligned_err_seen", n_err, 1);
        req_log.delete();
        base = n_deliv;
        exc_now = 1'b1; exc_addr_v = 32'hFFFF_FFF8;
        step();
        repeat (14) step();
        chk("wrap_req_count", {31'b0, req_log.size() >= 3}, 32'd1);
        if (req_log.size() >= 3) begin
            chk("wrap_req0", req_log[0], 32'hFFFF_FFF8);
            chk("wrap_req1", req_log[1], 32'hFFFF_FFFC);
            chk("wrap_req2", req_log[2], 32'h0000_0000);
        end
        chk("wrap_delivered", {31'b0, (n_deliv - base) >= 3}, 32'd1);

        // randomized stalls, memory latency, branches and exceptions
        do_reset();
        hand_mode = 1'b0; rand_mode = 1'b1;
        base = n_deliv;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 199) == 0) begin
                exc_now    = 1'b1;
                exc_addr_v = ($urandom_range(0, 1) == 1) ? A + 32'h380 : 32'h8000_0180;
            end
            step();
        end
        chk("random_delivered", {31'b0, (n_deliv - base) > 200}, 32'd1);
        rand_mode = 1'b0;

        // reset in the middle of traffic; a stale data_ok right after release is ignored
        do_reset();
        @(negedge clk);
        bus.inst_data_ok = 1'b1; bus.inst_rdata = 32'hDEAD_BEEF;
        #1;
        chk("post_rst_req", {31'b0, bus.inst_req}, 32'd1);
        chk("post_rst_addr", bus.inst_addr, A);
        @(negedge clk);
        bus.inst_data_ok = 1'b0;
        #1;
        chk("stale_data_valid", {31'b0, if_valid}, 32'd0);
        chk("stale_req_held", {31'b0, bus.inst_req}, 32'd1);
        chk("stale_addr_held", bus.inst_addr, A);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
